conv2d_top: RTL and testbench

- Streaming single-plane 3x3 2-D convolution engine: one signed pixel per clock, raster order, row width IMAGE_WIDTH, one output pixel per clock.
- Contains a 2-row line buffer, a 3x3 window shift register with zero padding on all four borders, and a 9-tap MAC against externally supplied kernel weights.
- Sits between the pixel source and the downstream pooling/BiLSTM stages of the CNN datapath.

---
 rtl/conv2d_top.sv | 172 +++++++++++++++++
 tb/tb_conv2d_top.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv2d_top.sv
// Streaming 3x3 convolution over a raster pixel stream: two-row line buffer,
// zero-padded 3x3 window and a saturating 9-tap MAC, one output per column event.
module conv2d_top #(
  parameter int IN_CHANNELS     = 4,
  parameter int OUT_CHANNELS    = 8,
  parameter int KERNEL_SIZE     = 3,
  parameter int STRIDE          = 1,
  parameter int PADDING         = 1,
  parameter int IMAGE_WIDTH     = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_PIXELS      = 1,
  parameter int MAX_POOL_KERNEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         pad_top,
  input  logic                         pad_bottom,
  input  logic                         start,
  input  logic                         next_channel,
  input  logic signed [DATA_WIDTH-1:0] pixel_in,
  input  logic signed [DATA_WIDTH-1:0] kernel_weights [0:2][0:2],
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] output_feature_map
);
  localparam int CW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW    = 16;
  localparam int FW    = $clog2(IMAGE_WIDTH + 2);
  localparam int ACC_W = 2 * DATA_WIDTH + 4;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (KERNEL_SIZE != 3 || PADDING != 1 || NUM_PIXELS != 1 || STRIDE < 1 ||
      IMAGE_WIDTH < 2 || IN_CHANNELS < 1 || OUT_CHANNELS < 1 || MAX_POOL_KERNEL < 1) begin : g_bad_cfg
    $error("conv2d_top: unsupported parameter combination");
  end

  typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_t;

  state_t                       r_state, w_state_nxt;
  logic [FW-1:0]                r_flush_cnt, w_flush_nxt;
  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic signed [DATA_WIDTH-1:0] r_lb0 [0:IMAGE_WIDTH-1];
  logic signed [DATA_WIDTH-1:0] r_lb1 [0:IMAGE_WIDTH-1];
  logic signed [DATA_WIDTH-1:0] r_win [0:2][0:2];

  logic                         w_restart, w_event, w_emit, w_neg_row;
  logic signed [DATA_WIDTH-1:0] w_pix;
  logic signed [DATA_WIDTH-1:0] w_vec [0:2];
  logic signed [DATA_WIDTH-1:0] w_tap [0:2][0:2];
  logic signed [2*DATA_WIDTH-1:0] w_prod [0:2][0:2];
  logic signed [ACC_W-1:0]      w_acc;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic [RW-1:0]                w_crow;
  logic [CW-1:0]                w_ccol;

  assign w_restart = pad_top | start | next_channel;

  // The pad_bottom cycle itself is the first of IMAGE_WIDTH+1 zero-pixel events.
  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_event     = 1'b0;
    w_pix       = pixel_in;
    if (w_restart) begin
      w_state_nxt = ST_RUN;
      w_flush_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (pad_bottom) begin
            w_event     = 1'b1;
            w_pix       = '0;
            w_flush_nxt = FW'(IMAGE_WIDTH);
            w_state_nxt = ST_FLUSH;
          end else if (valid_in) begin
            w_event = 1'b1;
          end
        end
        ST_FLUSH: begin
          w_event     = 1'b1;
          w_pix       = '0;
          w_flush_nxt = r_flush_cnt - FW'(1);
          if (r_flush_cnt == FW'(1)) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
    end
  end

  assign w_vec[0] = r_lb0[r_col];
  assign w_vec[1] = r_lb1[r_col];
  assign w_vec[2] = w_pix;

  // Taps are the window as it will look after this event's shift; the
  // out-of-image column is masked from the column counter, not from data.
  always_comb begin
    w_acc = '0;
    for (int r = 0; r < 3; r++) begin
      w_tap[r][0] = (r_col == CW'(1)) ? '0 : r_win[r][1];
      w_tap[r][1] = r_win[r][2];
      w_tap[r][2] = (r_col == '0) ? '0 : w_vec[r];
      for (int k = 0; k < 3; k++) begin
        w_prod[r][k] = w_tap[r][k] * kernel_weights[r][k];
        w_acc        = w_acc + ACC_W'(w_prod[r][k]);
      end
    end
    if (w_acc > SAT_MAX)      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_acc < SAT_MIN) w_sat = SAT_MIN[DATA_WIDTH-1:0];
    else                      w_sat = w_acc[DATA_WIDTH-1:0];
  end

  always_comb begin
    w_neg_row = (r_col == '0) ? (r_row < RW'(2)) : (r_row < RW'(1));
    w_crow    = (r_col == '0) ? (r_row - RW'(2)) : (r_row - RW'(1));
    w_ccol    = (r_col == '0) ? CW'(IMAGE_WIDTH - 1) : (r_col - CW'(1));
    w_emit    = w_event && !w_neg_row &&
                ((w_crow % RW'(STRIDE)) == '0) && ((w_ccol % CW'(STRIDE)) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_col <= '0;
      r_row <= '0;
      for (int i = 0; i < IMAGE_WIDTH; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) r_win[r][k] <= '0;
    end else if (w_event) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= w_vec[r];
      end
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= w_pix;
      if (r_col == CW'(IMAGE_WIDTH - 1)) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Restart only drops valid; the last result stays on the data output.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out          <= 1'b0;
      output_feature_map <= '0;
    end else begin
      valid_out <= w_emit;
      if (w_emit) output_feature_map <= w_sat;
    end
  end

endmodule

// File: tb/tb_conv2d_top.sv
// Self-checking bench for conv2d_top: frame-level scoreboard against a direct
// 3x3 zero-padded convolution model, plus tabled spot values and timing checks.
module tb_conv2d_top;
  localparam int W  = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst, valid_in, pad_top, pad_bottom, start, next_channel;
  logic signed [DW-1:0] pixel_in;
  logic signed [DW-1:0] kw [0:2][0:2];
  logic valid_out;
  logic signed [DW-1:0] ofm;

  conv2d_top #(.IMAGE_WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pad_top(pad_top),
    .pad_bottom(pad_bottom), .start(start), .next_channel(next_channel),
    .pixel_in(pixel_in), .kernel_weights(kw), .valid_out(valid_out),
    .output_feature_map(ofm)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int scen; int r; int c; int exp;} vec_t;
  vec_t tv [0:17];

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e_val;
  int img [0:15][0:W-1];
  logic signed [DW-1:0] cap [0:15][0:W-1];
  int cap_n, vcount, first_vcyc, last_vcyc;
  int acc11_cyc, pb_cyc, frame_start, l0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(int h, int r, int c);
    longint acc = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < h && c + dc >= 0 && c + dc < W)
          acc += longint'(img[r+dr][c+dc]) * longint'(kw[dr+1][dc+1]);
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return DW'(acc);
  endfunction

  // scoreboard: pop one expectation per valid_out
  always @(negedge clk) begin
    if (valid_out) begin
      vcount++;
      last_vcyc = cyc;
      if (vcount == 1) first_vcyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0d expected no output", int'(ofm));
      end else begin
        e_val = exp_q.pop_front();
        check("sb_stream", int'(ofm), int'($signed(e_val)));
      end
      if (cap_n < 16 * W) cap[cap_n / W][cap_n % W] = ofm;
      cap_n++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; pad_top = 0; pad_bottom = 0; start = 0; next_channel = 0;
  endtask

  task automatic set_kw(input int m);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        case (m)
          0:       kw[i][j] = DW'(1);
          1:       kw[i][j] = DW'(i * 3 + j + 1);
          2:       kw[i][j] = DW'(-1);
          3:       kw[i][j] = 16'h7FFF;
          default: kw[i][j] = 16'h8000;
        endcase
  endtask

  task automatic run_frame(input int h, input int mode, input int stall_at, input int abort_at);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < W; c++) img[r][c] = (mode == 0) ? r + c : 32767;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(model(h, r, c));
    cap_n = 0; vcount = 0; first_vcyc = -1; last_vcyc = -1; acc11_cyc = -1;
    pad_top = 1; tick(); tick(); pad_top = 0;
    frame_start = cyc;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < W; c++) begin
        if (r * W + c == abort_at) begin
          valid_in = 0; rst = 1; tick();
          check("rst_valid_out", int'(valid_out), 0);
          check("rst_data", int'(ofm), 0);
          rst = 0;
          exp_q.delete();
          return;
        end
        if (r * W + c == stall_at) begin
          valid_in = 0;
          repeat (5) tick();
        end
        valid_in = 1;
        pixel_in = DW'(img[r][c]);
        if (r == 1 && c == 1) acc11_cyc = cyc;
        tick();
      end
    valid_in = 0; pad_bottom = 1; pb_cyc = cyc; tick(); pad_bottom = 0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_table(input int s);
    for (int i = 0; i < 18; i++)
      if (tv[i].scen == s)
        check($sformatf("s%0d_center_%0d_%0d", s, tv[i].r, tv[i].c),
              int'(cap[tv[i].r][tv[i].c]), tv[i].exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1, 0, 0, 4};      tv[1]  = '{1, 0, 5, 33};
    tv[2]  = '{1, 0, 15, 60};    tv[3]  = '{1, 1, 1, 18};
    tv[4]  = '{1, 5, 7, 108};    tv[5]  = '{1, 9, 15, 92};
    tv[6]  = '{2, 1, 1, 114};    tv[7]  = '{2, 0, 0, 32};
    tv[8]  = '{3, 1, 1, -18};    tv[9]  = '{3, 0, 0, -4};
    tv[10] = '{4, 1, 1, 32767};  tv[11] = '{4, 0, 0, 32767};
    tv[12] = '{5, 1, 1, -32768}; tv[13] = '{5, 2, 15, -32768};
    tv[14] = '{6, 5, 7, 108};    tv[15] = '{6, 9, 15, 92};
    tv[16] = '{7, 0, 0, 4};      tv[17] = '{7, 0, 15, 60};

    idle(); pixel_in = '0; set_kw(0);
    cap_n = 0; vcount = 0;
    rst = 1; tick(); tick(); rst = 0;
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_data", int'(ofm), 0);

    // corners, edges, interior, flush timing
    run_frame(10, 0, -1, -1);
    check_table(1);
    check("first_valid_latency", first_vcyc - acc11_cyc, 1);
    check("flush_last_latency", last_vcyc - pb_cyc, 17);
    check("frame_count", vcount, 160);
    l0 = last_vcyc - frame_start;

    set_kw(1); run_frame(10, 0, -1, -1); check_table(2);
    set_kw(2); run_frame(10, 0, -1, -1); check_table(3);

    set_kw(3); run_frame(3, 1, -1, -1); check_table(4);
    check("sat_count", vcount, 48);
    set_kw(4); run_frame(3, 1, -1, -1); check_table(5);

    // mid-row stall shifts the whole output stream by the gap length
    set_kw(0); run_frame(10, 0, 4 * W + 7, -1); check_table(6);
    check("stall_count", vcount, 160);
    check("stall_delay", last_vcyc - frame_start, l0 + 5);

    // reset mid-frame, then a clean frame
    run_frame(10, 0, -1, 3 * W + 5);
    run_frame(10, 0, -1, -1); check_table(7);
    check("post_reset_count", vcount, 160);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
